// File: rtl/device_uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Bits are sampled at their midpoint from a 2-flop synchronised line.
module device_uart_rx #(
  parameter int CLKS_PER_BIT = 5200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serialInputRx,
  input  logic       clearRx,
  output logic [7:0] dataReceived,
  output logic       rxDone,
  output logic       rxFlag,
  output logic       parityError,
  output logic       frameError,
  output logic       busyRx
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic          meta_q;
  logic          line_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          stop_q, stop_d;
  logic [7:0]    data_q, data_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          flag_q, flag_d;

  logic cnt_last;
  logic cnt_half;
  logic rx_done;
  logic busy;
  logic smp_data;
  logic smp_par;
  logic smp_stop;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign cnt_half = (cnt_q == CNT_HALF);

  // Line idles high, so the synchroniser resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      line_q <= 1'b1;
    end else begin
      meta_q <= serialInputRx;
      line_q <= meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!line_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_half) state_d = line_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_last && bit_q == 3'd7) state_d = S_PARITY;
      end
      S_PARITY: begin
        if (cnt_last) state_d = S_STOP;
      end
      S_STOP: begin
        if (cnt_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rx_done  = 1'b0;
    busy     = 1'b1;
    smp_data = 1'b0;
    smp_par  = 1'b0;
    smp_stop = 1'b0;
    unique case (state_q)
      S_IDLE:   busy     = 1'b0;
      S_DATA:   smp_data = cnt_last;
      S_PARITY: smp_par  = cnt_last;
      S_STOP:   smp_stop = cnt_last;
      S_DONE:   rx_done  = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    flag_d  = flag_q;
    if (state_d != state_q || cnt_last) cnt_d = '0;
    if (state_q == S_START) bit_d = '0;
    if (smp_data) begin
      shift_d[bit_q] = line_q;
      bit_d          = bit_q + 3'd1;
    end
    if (smp_par)  par_d  = line_q;
    if (smp_stop) stop_d = line_q;
    if (clearRx)  flag_d = 1'b0;
    // Commit happens even for bad frames; a set beats a same-cycle clear.
    if (rx_done) begin
      data_d = shift_q;
      perr_d = ^shift_q ^ par_q;
      ferr_d = ~stop_q;
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      flag_q  <= flag_d;
    end
  end

  assign dataReceived = data_q;
  assign rxDone       = rx_done;
  assign rxFlag       = flag_q;
  assign parityError  = perr_q;
  assign frameError   = ferr_q;
  assign busyRx       = busy;

endmodule

// File: tb/tb_device_uart_rx.sv
// Bench for device_uart_rx at 16 clocks per bit: vector table,
// randomized frames against a parity/stop model, and corner sequences.
module tb_device_uart_rx;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       pad;
  logic       clearRx;
  logic [7:0] dataReceived;
  logic       rxDone;
  logic       rxFlag;
  logic       parityError;
  logic       frameError;
  logic       busyRx;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int start_cyc = 0;
  bit prev_done = 1'b0;

  device_uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serialInputRx(pad),
    .clearRx      (clearRx),
    .dataReceived (dataReceived),
    .rxDone       (rxDone),
    .rxFlag       (rxFlag),
    .parityError  (parityError),
    .frameError   (frameError),
    .busyRx       (busyRx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rxDone === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
      n_chk++;
      if (prev_done) begin
        n_fail++;
        $display("FAIL rxDone_single: high %0d cycles in a row, required 1", 2);
      end
    end
    prev_done = (rxDone === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    pad = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic check_frame(input string nm, input int d0,
                             input logic [7:0] ed, input logic ep,
                             input logic ef);
    chk({nm, "_done"}, done_cnt - d0, 1);
    chk({nm, "_data"}, dataReceived, ed);
    chk({nm, "_parityError"}, parityError, ep);
    chk({nm, "_frameError"}, frameError, ef);
    chk({nm, "_rxFlag"}, rxFlag, 1);
    chk_rng({nm, "_latency"}, last_done_cyc - start_cyc, LAT - 1, LAT + 1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int d0;
    int c1;
    logic [7:0] rd;
    logic rp;
    logic rs;
    logic [7:0] sv_data;
    logic sv_flag;
    logic sv_pe;
    logic sv_fe;

    tbl[0] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[2] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
    tbl[5] = '{8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};

    rst = 1'b1;
    pad = 1'b1;
    clearRx = 1'b0;
    tick(3);
    chk("rst_data", dataReceived, 8'h00);
    chk("rst_rxDone", rxDone, 0);
    chk("rst_rxFlag", rxFlag, 0);
    chk("rst_parityError", parityError, 0);
    chk("rst_frameError", frameError, 0);
    chk("rst_busyRx", busyRx, 0);
    rst = 1'b0;
    tick(5);

    // 0xA5, good frame, then clear the flag
    d0 = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    pad = 1'b1;
    tick(2);
    check_frame("a5", d0, 8'hA5, 1'b0, 1'b0);
    clearRx = 1'b1;
    tick(1);
    clearRx = 1'b0;
    chk("a5_cleared_flag", rxFlag, 0);
    chk("a5_data_held", dataReceived, 8'hA5);

    for (int i = 0; i < 6; i++) begin
      pad = 1'b1;
      tick(20);
      clearRx = 1'b1;
      tick(1);
      clearRx = 1'b0;
      d0 = done_cnt;
      send_frame(tbl[i].d, tbl[i].p, tbl[i].s);
      pad = 1'b1;
      tick(2);
      check_frame($sformatf("vec%0d", i), d0, tbl[i].ed, tbl[i].ep,
                  tbl[i].ef);
    end

    // bad stop with line held low afterwards, then a clean frame
    pad = 1'b1;
    tick(20);
    d0 = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(2);
    check_frame("stop0", d0, 8'h3C, 1'b0, 1'b1);
    tick(38);
    pad = 1'b1;
    tick(250);
    d0 = done_cnt;
    send_frame(8'h11, 1'b0, 1'b1);
    pad = 1'b1;
    tick(2);
    check_frame("after_stop0", d0, 8'h11, 1'b0, 1'b0);

    // short low glitch is a false start
    tick(20);
    sv_data = dataReceived;
    sv_flag = rxFlag;
    sv_pe = parityError;
    sv_fe = frameError;
    d0 = done_cnt;
    pad = 1'b0;
    tick(5);
    chk("glitch_busy", busyRx, 1);
    pad = 1'b1;
    tick(30);
    chk("glitch_idle", busyRx, 0);
    chk("glitch_no_done", done_cnt - d0, 0);
    chk("glitch_data", dataReceived, sv_data);
    chk("glitch_flag", rxFlag, sv_flag);
    chk("glitch_pe", parityError, sv_pe);
    chk("glitch_fe", frameError, sv_fe);

    // back-to-back frames
    d0 = done_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    check_frame("b2b_55", d0, 8'h55, 1'b0, 1'b0);
    c1 = last_done_cyc;
    send_frame(8'hAA, 1'b0, 1'b1);
    pad = 1'b1;
    tick(2);
    check_frame("b2b_aa", d0 + 1, 8'hAA, 1'b0, 1'b0);
    chk("b2b_spacing", last_done_cyc - c1, 11 * CPB);

    // set on commit wins over a simultaneous clear
    tick(20);
    clearRx = 1'b1;
    fork
      send_frame(8'h3E, 1'b1, 1'b1);
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (rxDone !== 1'b1 && w < 400) begin
          @(negedge clk);
          w++;
        end
        chk("setwins_seen_done", rxDone, 1);
        chk("setwins_flag_before", rxFlag, 0);
        @(negedge clk);
        clearRx = 1'b0;
        chk("setwins_flag_after", rxFlag, 1);
        chk("setwins_data", dataReceived, 8'h3E);
      end
    join
    pad = 1'b1;

    // reset mid-frame
    tick(20);
    d0 = done_cnt;
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    chk("midrst_busy", busyRx, 1);
    rst = 1'b1;
    pad = 1'b1;
    tick(1);
    chk("midrst_data", dataReceived, 8'h00);
    chk("midrst_flag", rxFlag, 0);
    chk("midrst_pe", parityError, 0);
    chk("midrst_fe", frameError, 0);
    chk("midrst_busy_low", busyRx, 0);
    tick(1);
    rst = 1'b0;
    tick(200);
    chk("midrst_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    send_frame(8'h81, 1'b0, 1'b1);
    pad = 1'b1;
    tick(2);
    check_frame("after_rst", d0, 8'h81, 1'b0, 1'b0);

    // random frames against the parity/stop model
    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      pad = 1'b1;
      tick($urandom_range(20, 40));
      if ($urandom_range(0, 1) == 1) begin
        clearRx = 1'b1;
        tick(1);
        clearRx = 1'b0;
      end
      d0 = done_cnt;
      send_frame(rd, rp, rs);
      pad = 1'b1;
      tick(2);
      check_frame($sformatf("rnd%0d", i), d0, rd, (^rd) ^ rp, ~rs);
    end

    tick(20);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/device_uart_rx.md
Name: device_uart_rx

Overview:
UART receiver that pairs with the team's UART transmitter. It deserialises a frame of start bit (0), 8 data bits sent LSB first, one even-parity bit, and stop bit (1). It samples each bit at its midpoint using a baud counter and presents the byte in parallel with error flags. It sits between the rx pad and the memory-mapped UART peripheral registers.

Parameters:
CLKS_PER_BIT, 5200, clock cycles per bit period (the transmitter divider counts 0..5199).
HALF_BIT, CLKS_PER_BIT/2, cycles from the start-bit falling edge to the start-bit midpoint (derived; do not override).

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
serialInputRx  input  1  asynchronous serial line; idles high.
clearRx  input  1  clears the sticky rxFlag.
dataReceived  output  8  last received byte; held until the next frame completes.
rxDone  output  1  one-cycle pulse when a frame completes.
rxFlag  output  1  sticky "byte available" flag.
parityError  output  1  parity result of the last frame.
frameError  output  1  stop-bit result of the last frame.
busyRx  output  1  high in every state other than IDLE.

Behaviour:
- Input conditioning: 2-flop synchroniser on serialInputRx. All references to the "line" below mean the synchronised signal (2-cycle latency). Reset value of both flops is 1.
- Reset (rst=1 at a clock edge): state=IDLE; dataReceived=0x00; rxDone=0; rxFlag=0; parityError=0; frameError=0; busyRx=0; bit and baud counters=0. Reset in mid-frame abandons the frame. No outputs update for the partial frame.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. It reloads to 0 on every state transition.
- State machine (one-hot or binary; states are fixed):
  - IDLE: waits for line=0, then goes to START.
  - START: at count HALF_BIT-1, sample the line. If 0 -> DATA with bitIdx=0. If 1 -> IDLE (false start, no outputs change).
  - DATA: at count CLKS_PER_BIT-1, sample into shift[bitIdx] (LSB first) and increment bitIdx. After bitIdx=7 is sampled -> PARITY.
  - PARITY: at count CLKS_PER_BIT-1, sample parBit -> STOP.
  - STOP: at count CLKS_PER_BIT-1, sample stopBit -> DONE.
  - DONE: one cycle, then -> IDLE unconditionally. In this cycle:
    - dataReceived <= shift
    - parityError <= ^shift ^ parBit (even parity: XOR of the 8 data bits and the parity bit must be 0)
    - frameError <= ~stopBit
    - rxDone=1
    - rxFlag <= 1
- Data and flags update even when parityError or frameError is set. Software decides what to do with a bad frame.
- rxFlag: set in DONE, cleared when clearRx=1 in IDLE or any other state. If DONE and clearRx=1 occur in the same cycle, the set wins.
- rxDone is high only in DONE; it is never high for two consecutive cycles.
- After a bad stop bit (line still 0), the return to IDLE sees line=0 and starts a new frame immediately. This is the required behaviour, not an error.
- Back-to-back frames: the start edge of the next frame begins no earlier than half a bit after the stop midpoint, so IDLE always catches it.
- Latency: rxDone rises 2 + HALF_BIT + 10*CLKS_PER_BIT + 1 cycles (±1) after the start-bit falling edge on the pad.
- No combinational path from serialInputRx to any output.

Test Plan:
(All benches use CLKS_PER_BIT=16.)
1. Send frame 0xA5 with parity bit 0 and stop bit 1 -> one rxDone pulse; dataReceived=0xA5, parityError=0, frameError=0, rxFlag=1. Then pulse clearRx -> rxFlag=0 while dataReceived stays 0xA5.
2. Send 0x07 with parity bit 0 (wrong; the correct bit is 1) -> dataReceived=0x07, parityError=1, frameError=0, rxDone pulses once.
3. Send 0x3C with correct parity 0 and stop bit driven 0 -> frameError=1, dataReceived=0x3C. Then hold the line low, release it, and send 0x11 -> the next valid frame is received as 0x11 with frameError=0.
4. Drive a low glitch of 5 cycles, shorter than HALF_BIT=8 -> busyRx pulses, then returns to IDLE; no rxDone, and all outputs unchanged.
5. Send 0x55 then 0xAA back-to-back (the next start bit immediately follows the stop bit) -> two rxDone pulses 11*16 cycles apart; dataReceived reads 0x55 then 0xAA; parity flags are 0.
6. Assert rst in the middle of DATA for frame 0xFF -> all outputs go to reset values on the next edge; no rxDone for that frame. A subsequent frame 0x81 is received correctly.
